data_enable: RTL and testbench

- Per-PE systolic enable and operand forwarding stage for the tensor-core PE array.
- Passes the A operand left to right and the B operand top to bottom, each with one registered stage and its valid/enable tag.
- Produces the local combinational compute enable for the PE's MAC.
- One instance per PE; the enable outputs chain into the right and lower neighbours.

---
 rtl/data_enable.sv | 47 ++++
 tb/tb_data_enable.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_enable.sv
// Systolic PE operand forwarding: A moves right, B moves down, each through one register with its valid.
// Latency 1 cycle on both paths; en is combinational; no backpressure, downstream always accepts.
module data_enable #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enleft,
  input  logic [DATA_W-1:0] data_left,
  output logic              enright,
  output logic [DATA_W-1:0] data_right,
  input  logic              enabove,
  input  logic [DATA_W-1:0] data_above,
  output logic              enbelow,
  output logic [DATA_W-1:0] data_below,
  output logic              en
);

  // The MAC fires only when both operands are present in this cycle.
  assign en = enleft & enabove;

  always_ff @(posedge clk) begin
    if (rst) begin
      enright    <= 1'b0;
      data_right <= '0;
    end else begin
      enright <= enleft;
      if (enleft) begin
        data_right <= data_left;
      end
    end
  end

  // The vertical path is fully independent of the horizontal one.
  always_ff @(posedge clk) begin
    if (rst) begin
      enbelow    <= 1'b0;
      data_below <= '0;
    end else begin
      enbelow <= enabove;
      if (enabove) begin
        data_below <= data_above;
      end
    end
  end

endmodule

// File: tb/tb_data_enable.sv
// Scoreboard bench for data_enable: expected registered outputs are queued at drive time and compared after the edge.
module tb_data_enable;
  localparam int DATA_W = 32;

  logic              clk;
  logic              rst;
  logic              enleft;
  logic [DATA_W-1:0] data_left;
  logic              enright;
  logic [DATA_W-1:0] data_right;
  logic              enabove;
  logic [DATA_W-1:0] data_above;
  logic              enbelow;
  logic [DATA_W-1:0] data_below;
  logic              en;

  typedef struct packed {
    logic              er;
    logic [DATA_W-1:0] dr;
    logic              eb;
    logic [DATA_W-1:0] db;
  } out_t;

  out_t exp_q[$];
  out_t model;
  out_t got;
  out_t exp_v;
  int   n_checks;
  int   n_fail;

  data_enable #(.DATA_W(DATA_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .enleft     (enleft),
    .data_left  (data_left),
    .enright    (enright),
    .data_right (data_right),
    .enabove    (enabove),
    .data_above (data_above),
    .enbelow    (enbelow),
    .data_below (data_below),
    .en         (en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply one cycle of inputs and queue what the registers must hold after the next edge.
  task automatic drive(input logic r, input logic el, input logic [DATA_W-1:0] dl,
                       input logic ea, input logic [DATA_W-1:0] da);
    rst        = r;
    enleft     = el;
    data_left  = dl;
    enabove    = ea;
    data_above = da;
    if (r) begin
      model = '0;
    end else begin
      model.er = el;
      if (el) model.dr = dl;
      model.eb = ea;
      if (ea) model.db = da;
    end
    exp_q.push_back(model);
    #1;
  endtask

  task automatic test_reset;
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b1, 32'hDEADBEEF, 1'b1, 32'hDEADBEEF);
      n_checks++;
      if (en !== 1'b1) begin
        n_fail++;
        $display("FAIL reset_en cyc%0d: got %b want 1", i, en);
      end
      @(posedge clk); #1;
      exp_v = exp_q.pop_front();
      got = '{enright, data_right, enbelow, data_below};
      n_checks++;
      if (got !== exp_v || got !== out_t'(0)) begin
        n_fail++;
        $display("FAIL reset_out cyc%0d: got %h want %h", i, got, exp_v);
      end
    end
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    @(posedge clk); #1;
    exp_v = exp_q.pop_front();
    got = '{enright, data_right, enbelow, data_below};
    n_checks++;
    if (got !== exp_v || got !== out_t'(0)) begin
      n_fail++;
      $display("FAIL reset_after: got %h want %h", got, exp_v);
    end
  endtask

  task automatic test_single_a;
    drive(1'b0, 1'b1, 32'h3F800000, 1'b0, 32'h0);
    n_checks++;
    if (en !== 1'b0) begin
      n_fail++;
      $display("FAIL single_a_en: got %b want 0", en);
    end
    @(posedge clk); #1;
    exp_v = exp_q.pop_front();
    n_checks++;
    if (enright !== 1'b1 || data_right !== 32'h3F800000 || enbelow !== exp_v.eb || data_below !== exp_v.db) begin
      n_fail++;
      $display("FAIL single_a_fwd: got er=%b dr=%h eb=%b db=%h want er=1 dr=3f800000 eb=%b db=%h",
               enright, data_right, enbelow, data_below, exp_v.eb, exp_v.db);
    end
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    @(posedge clk); #1;
    exp_v = exp_q.pop_front();
    n_checks++;
    if (enright !== 1'b0 || data_right !== 32'h3F800000 || enbelow !== exp_v.eb) begin
      n_fail++;
      $display("FAIL single_a_drop: got er=%b dr=%h want er=0 dr=3f800000", enright, data_right);
    end
  endtask

  task automatic test_single_b;
    drive(1'b0, 1'b0, 32'hFFFF0000, 1'b1, 32'h0BADF00D);
    n_checks++;
    if (en !== 1'b0) begin
      n_fail++;
      $display("FAIL single_b_en: got %b want 0", en);
    end
    @(posedge clk); #1;
    exp_v = exp_q.pop_front();
    got = '{enright, data_right, enbelow, data_below};
    n_checks++;
    if (got !== exp_v || enbelow !== 1'b1 || data_below !== 32'h0BADF00D || enright !== 1'b0) begin
      n_fail++;
      $display("FAIL single_b_fwd: got %h want %h", got, exp_v);
    end
  endtask

  task automatic test_coincident;
    drive(1'b0, 1'b1, 32'h11223344, 1'b1, 32'hA5A5A5A5);
    n_checks++;
    if (en !== 1'b1) begin
      n_fail++;
      $display("FAIL coincident_en: got %b want 1", en);
    end
    @(posedge clk); #1;
    exp_v = exp_q.pop_front();
    n_checks++;
    if (enright !== 1'b1 || enbelow !== 1'b1 || data_right !== 32'h11223344 || data_below !== 32'hA5A5A5A5) begin
      n_fail++;
      $display("FAIL coincident_out: got er=%b eb=%b dr=%h db=%h want 1 1 11223344 a5a5a5a5",
               enright, enbelow, data_right, data_below);
    end
  endtask

  task automatic test_streaming;
    int en_cycles;
    en_cycles = 0;
    for (int i = 1; i <= 5; i++) begin
      if (i <= 4) drive(1'b0, 1'b1, 32'(i), 1'b1, 32'(i * 16));
      else        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      if (en === 1'b1) en_cycles++;
      @(posedge clk); #1;
      exp_v = exp_q.pop_front();
      got = '{enright, data_right, enbelow, data_below};
      n_checks++;
      if (got !== exp_v) begin
        n_fail++;
        $display("FAIL stream_out beat%0d: got %h want %h", i, got, exp_v);
      end
      if (i <= 4) begin
        n_checks++;
        if (enright !== 1'b1 || data_right !== 32'(i)) begin
          n_fail++;
          $display("FAIL stream_gap beat%0d: got er=%b dr=%h want er=1 dr=%h", i, enright, data_right, 32'(i));
        end
      end
    end
    n_checks++;
    if (en_cycles != 4) begin
      n_fail++;
      $display("FAIL stream_en_count: got %0d want 4", en_cycles);
    end
  endtask

  task automatic test_hold;
    drive(1'b0, 1'b1, 32'h55, 1'b0, 32'h0);
    @(posedge clk); #1;
    exp_v = exp_q.pop_front();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 32'hFF, 1'b0, 32'hFF);
      @(posedge clk); #1;
      exp_v = exp_q.pop_front();
      n_checks++;
      if (enright !== 1'b0 || data_right !== 32'h55 || data_below !== exp_v.db) begin
        n_fail++;
        $display("FAIL hold cyc%0d: got er=%b dr=%h db=%h want er=0 dr=55 db=%h",
                 i, enright, data_right, data_below, exp_v.db);
      end
    end
  endtask

  task automatic test_reset_midstream;
    logic [DATA_W-1:0] vals [4];
    vals = '{32'h10, 32'h20, 32'h30, 32'h40};
    for (int i = 0; i < 4; i++) begin
      drive((i == 1), 1'b1, vals[i], 1'b1, ~vals[i]);
      @(posedge clk); #1;
      exp_v = exp_q.pop_front();
      got = '{enright, data_right, enbelow, data_below};
      n_checks++;
      if (got !== exp_v) begin
        n_fail++;
        $display("FAIL midrst_out cyc%0d: got %h want %h", i, got, exp_v);
      end
      if (i == 1) begin
        n_checks++;
        if (got !== out_t'(0)) begin
          n_fail++;
          $display("FAIL midrst_zero: got %h want 0", got);
        end
      end
    end
  endtask

  task automatic test_back_to_back_random;
    logic el, ea;
    logic [DATA_W-1:0] dl, da;
    for (int i = 0; i < 60; i++) begin
      el = 1'($urandom_range(0, 1));
      ea = 1'($urandom_range(0, 1));
      dl = $urandom;
      da = $urandom;
      drive((i % 23 == 22), el, dl, ea, da);
      n_checks++;
      if (en !== (el & ea)) begin
        n_fail++;
        $display("FAIL rand_en cyc%0d: got %b want %b", i, en, el & ea);
      end
      @(posedge clk); #1;
      exp_v = exp_q.pop_front();
      got = '{enright, data_right, enbelow, data_below};
      n_checks++;
      if (got !== exp_v) begin
        n_fail++;
        $display("FAIL rand_out cyc%0d: got %h want %h", i, got, exp_v);
      end
    end
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    model      = '0;
    rst        = 1'b1;
    enleft     = 1'b0;
    enabove    = 1'b0;
    data_left  = '0;
    data_above = '0;
    test_reset();
    test_single_a();
    test_single_b();
    test_coincident();
    test_streaming();
    test_hold();
    test_reset_midstream();
    test_back_to_back_random();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d entries left want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
